// File: rtl/keypad_pkg.sv
// Shared types and constants for the microwave keypad scanner.
package keypad_pkg;

  localparam int unsigned KEYPAD_N_KEYS = 12;

  localparam logic [3:0] KEY_START = 4'd10;
  localparam logic [3:0] KEY_STOP  = 4'd11;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHold,
    StRelease
  } kp_state_e;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser applied bitwise to a bus of asynchronous key levels.
module key_sync #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scan_controller.sv
// Keypad scanner: one shared debounce counter serves the lowest-index pressed key.
// Build option KEY_REPEAT_EN adds auto-repeat of held digit keys.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int unsigned N_KEYS        = KEYPAD_N_KEYS,
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_raw,
  output logic              key_valid,
  output logic [3:0]        key_code,
  output logic              busy,
  output logic              stop_level
);

  localparam logic [7:0] DebLast = 8'(DEB_CYCLES - 1);

  logic [N_KEYS-1:0] keys_s;
  kp_state_e         state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        own_q, own_d;
  logic              valid_d;
  logic [3:0]        code_d;
  logic [3:0]        first_key;
  logic              own_hit;

  key_sync #(
    .Width(N_KEYS)
  ) u_key_sync (
    .clk  (clk),
    .reset(reset),
    .d    (keys_raw),
    .q    (keys_s)
  );

  // Lowest index wins when several keys are seen in the same cycle.
  always_comb begin
    first_key = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (keys_s[i]) first_key = 4'(i);
    end
  end

  assign own_hit = keys_s[own_q];

`ifdef KEY_REPEAT_EN
  localparam logic [15:0] RptLast = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rpt_q, rpt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CYCLES == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      own_q     <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      key_valid <= valid_d;
      key_code  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    valid_d = 1'b0;
    code_d  = key_code;
`ifdef KEY_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|keys_s) begin
          own_d   = first_key;
          cnt_d   = '0;
          state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (!own_hit) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          valid_d = 1'b1;
          code_d  = own_q;
          cnt_d   = '0;
          state_d = StHold;
`ifdef KEY_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (own_hit) begin
          cnt_d = '0;
`ifdef KEY_REPEAT_EN
          if (own_q < KEY_START) begin
            if (rpt_q == RptLast) begin
              valid_d = 1'b1;
              code_d  = own_q;
              rpt_d   = '0;
            end else begin
              rpt_d = rpt_q + 16'd1;
            end
          end
`endif
        end else begin
`ifdef KEY_REPEAT_EN
          // A release glitch restarts the repeat period.
          rpt_d = '0;
`endif
          if (cnt_q == DebLast) state_d = StRelease;
          else                  cnt_d   = cnt_q + 8'd1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    stop_level = (state_q == StHold) && (own_q == KEY_STOP);
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Self-checking bench: directed scenarios plus random key traffic against a behavioural model.
module tb_keypad_scan_controller;

  localparam int unsigned NK  = 12;
  localparam int unsigned DEB = 4;
  localparam int unsigned RPT = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] keys_raw = '0;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          busy;
  logic          stop_level;

  keypad_scan_controller #(
    .N_KEYS       (NK),
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .keys_raw  (keys_raw),
    .key_valid (key_valid),
    .key_code  (key_code),
    .busy      (busy),
    .stop_level(stop_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: raw samples delayed two edges, then owner / streak bookkeeping.
  logic [NK-1:0] m_s1, m_s2, m_ks;
  int            m_own = -1;
  bit            m_fired, m_gap;
  int            m_since, m_hold_run;
  int            lo_run[NK];
  bit            exp_valid;
  int            exp_code;

  int ev_cyc[$];
  int ev_code[$];
  int m_ev_cyc[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest(logic [NK-1:0] v);
    for (int k = 0; k < int'(NK); k++) if (v[k]) return k;
    return -1;
  endfunction

  task model_reset();
    m_s1 = '0; m_s2 = '0; m_own = -1; m_fired = 0; m_gap = 0;
    m_since = 0; m_hold_run = 0; exp_valid = 0; exp_code = 0;
    foreach (lo_run[k]) lo_run[k] = 0;
  endtask

  task model_step();
    m_ks = m_s2;
    foreach (lo_run[k]) lo_run[k] = m_ks[k] ? 0 : lo_run[k] + 1;
    exp_valid = 0;
    if (m_gap) begin
      m_gap = 0;
      m_own = -1;
    end else if (m_own < 0) begin
      if (m_ks != '0) begin
        m_own = lowest(m_ks); m_fired = 0; m_since = 0;
      end
    end else if (!m_fired) begin
      if (!m_ks[m_own]) m_own = -1;
      else begin
        m_since++;
        if (m_since == int'(DEB)) begin
          exp_valid = 1; exp_code = m_own; m_fired = 1; m_hold_run = 0;
        end
      end
    end else begin
      if (m_ks[m_own]) begin
        m_hold_run++;
`ifdef KEY_REPEAT_EN
        if (m_own < 10 && (m_hold_run % int'(RPT)) == 0) begin
          exp_valid = 1; exp_code = m_own;
        end
`endif
      end else begin
        m_hold_run = 0;
        if (lo_run[m_own] == int'(DEB)) m_gap = 1;
      end
    end
    m_s2 = m_s1;
    m_s1 = keys_raw;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (clk) cyc++;
    if (reset) model_reset();
    else       model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("key_valid", int'(key_valid), int'(exp_valid));
    chk("key_code", int'(key_code), exp_code);
    chk("busy", int'(busy), int'(m_own >= 0));
    chk("stop_level", int'(stop_level), int'(m_own == 11 && m_fired && !m_gap));
    if (key_valid) begin
      ev_cyc.push_back(cyc);
      ev_code.push_back(int'(key_code));
    end
    if (exp_valid) m_ev_cyc.push_back(cyc);
  end

  task tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task ev_chk(string name, int idx, int d, int rel, int code);
    if (ev_cyc.size() > idx) begin
      chk({name, "_cycle"}, ev_cyc[idx] - d, rel);
      chk({name, "_code"}, ev_code[idx], code);
    end else begin
      chk({name, "_missing"}, ev_cyc.size(), idx + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int d, r, q, base, mbase;
    tick(3);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stop", int'(stop_level), 0);
    reset = 1'b0;
    tick(5);

    // Basic press of key 5.
    base = ev_cyc.size(); mbase = m_ev_cyc.size(); d = cyc;
    keys_raw[5] = 1'b1; tick(20); keys_raw[5] = 1'b0; r = cyc;
    wait_cyc(r + 6); chk("basic_busy_release", int'(busy), 1);
    wait_cyc(r + 7); chk("basic_busy_idle", int'(busy), 0);
    ev_chk("basic", base, d, 7, 5);
    if (m_ev_cyc.size() > mbase) chk("model_latency", m_ev_cyc[mbase] - d, 7);
    else chk("model_latency_missing", m_ev_cyc.size() - mbase, 1);
`ifndef KEY_REPEAT_EN
    chk("basic_count", ev_cyc.size() - base, 1);
`endif
    tick(3);

    // Bounce on key 2: never stable for DEB samples.
    base = ev_cyc.size();
    repeat (5) begin
      keys_raw[2] = 1'b1; tick(2); keys_raw[2] = 1'b0; tick(1);
    end
    tick(10);
    chk("bounce_count", ev_cyc.size() - base, 0);
    chk("bounce_busy", int'(busy), 0);

    // Keys 3 and 7 together: 3 first, 7 after 3's release.
    base = ev_cyc.size(); mbase = m_ev_cyc.size(); d = cyc;
    keys_raw[3] = 1'b1; keys_raw[7] = 1'b1; tick(30);
    keys_raw[3] = 1'b0; tick(20);
    keys_raw[7] = 1'b0; tick(15);
    ev_chk("prio_first", base, d, 7, 3);
`ifndef KEY_REPEAT_EN
    ev_chk("prio_second", base + 1, d, 42, 7);
    if (m_ev_cyc.size() > mbase + 1) chk("model_prio", m_ev_cyc[mbase + 1] - d, 42);
    else chk("model_prio_missing", m_ev_cyc.size() - mbase, 2);
    chk("prio_count", ev_cyc.size() - base, 2);
`endif

    // Key 9 with a one-cycle release glitch mid-hold.
    base = ev_cyc.size(); d = cyc;
    keys_raw[9] = 1'b1; tick(12);
    keys_raw[9] = 1'b0; tick(1); keys_raw[9] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_busy", int'(busy), 1);
    end
    chk("glitch_stop", int'(stop_level), 0);
    keys_raw[9] = 1'b0; tick(12);
    ev_chk("glitch", base, d, 7, 9);
`ifndef KEY_REPEAT_EN
    chk("glitch_count", ev_cyc.size() - base, 1);
`endif

    // STOP key level.
    d = cyc; keys_raw[11] = 1'b1;
    wait_cyc(d + 6); chk("stop_in_debounce", int'(stop_level), 0);
    wait_cyc(d + 8); chk("stop_in_hold", int'(stop_level), 1);
    chk("stop_code", int'(key_code), 11);
    keys_raw[11] = 1'b0; r = cyc;
    wait_cyc(r + 6); chk("stop_in_release", int'(stop_level), 0);
    tick(4);

    // Reset two cycles into DEBOUNCE while key 6 stays held.
    base = ev_cyc.size(); d = cyc;
    keys_raw[6] = 1'b1;
    wait_cyc(d + 5);
    reset = 1'b1;
    #1;
    chk("midrst_valid", int'(key_valid), 0);
    chk("midrst_code", int'(key_code), 0);
    chk("midrst_busy", int'(busy), 0);
    tick(2);
    reset = 1'b0; q = cyc;
    tick(10);
    ev_chk("midrst_restart", base, q, 7, 6);
    keys_raw[6] = 1'b0; tick(12);

`ifdef KEY_REPEAT_EN
    // Digit 4 repeats every RPT cycles; START does not.
    base = ev_cyc.size(); d = cyc;
    keys_raw[4] = 1'b1; tick(50); keys_raw[4] = 1'b0; tick(12);
    chk("rpt_digit_count", ev_cyc.size() - base, 5);
    ev_chk("rpt_digit_last", base + 4, d, 47, 4);
    base = ev_cyc.size(); d = cyc;
    keys_raw[10] = 1'b1; tick(50); keys_raw[10] = 1'b0; tick(12);
    chk("rpt_start_count", ev_cyc.size() - base, 1);
    ev_chk("rpt_start", base, d, 7, 10);
`endif

    // Random key traffic, checked every cycle by the model.
    repeat (300) begin
      int len, sel;
      logic [NK-1:0] mask;
      len = $urandom_range(1, 14);
      sel = $urandom_range(0, 9);
      mask = '0;
      if (sel < 4) mask[$urandom_range(0, NK - 1)] = 1'b1;
      else if (sel < 6) begin
        mask[$urandom_range(0, NK - 1)] = 1'b1;
        mask[$urandom_range(0, NK - 1)] = 1'b1;
      end else if (sel >= 8) mask = NK'($urandom);
      for (int i = 0; i < len; i++) begin
        keys_raw = mask;
        if ($urandom_range(0, 7) == 0) keys_raw[$urandom_range(0, NK - 1)] ^= 1'b1;
        tick(1);
      end
    end
    keys_raw = '0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
- Shares one debounce counter among all microwave keypad buttons: digits 0-9, START and STOP.
- Sits between the raw front-panel button pins and the timer/cooking control logic.
- Synchronises the raw inputs and arbitrates simultaneous presses by fixed priority.
- Debounces only the selected key, then emits a single-cycle key event with a 4-bit key code.

Parameters:
- N_KEYS, 12, number of raw key inputs; index 0-9 = digits, 10 = START, 11 = STOP.
- DEB_CYCLES, 4, consecutive stable synchronised samples required to accept a press or a release; range 1..255.
- REPEAT_CYCLES, 1000, auto-repeat period in cycles; used only with KEY_REPEAT_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- keys_raw  input  N_KEYS  raw button levels, asynchronous; 1 = pressed.
- key_valid  output  1  one-cycle pulse marking an accepted key event.
- key_code  output  4  index of the accepted key; holds its value until the next event.
- busy  output  1  high whenever the FSM is not in IDLE.
- stop_level  output  1  debounced level of key 11 while it is the owned key, else 0.

Behaviour:
- Reset: asynchronous, active-high.
  - While reset is high: all outputs = 0, both synchroniser stages = 0, state = IDLE, counter = 0.
- Synchroniser: two flip-flop stages on every key bit, giving keys_s.
  - All FSM decisions use keys_s, never keys_raw.
- Counter: one shared 8-bit debounce counter, cnt.
- Owned-key register: own, 4 bits.
- IDLE:
  - If any keys_s bit is high: own <= index of the lowest set bit (lowest index wins), cnt <= 0, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - If keys_s[own] = 0: go to IDLE with no event.
  - Else if cnt = DEB_CYCLES-1: key_valid <= 1 for one cycle, key_code <= own, cnt <= 0, go to HOLD.
  - Else: cnt <= cnt+1.
- HOLD:
  - If keys_s[own] = 1: cnt <= 0.
  - Else if cnt = DEB_CYCLES-1: go to RELEASE.
  - Else: cnt <= cnt+1.
- RELEASE:
  - Lasts one cycle, then goes to IDLE.
  - Gives one guaranteed idle gap before the next capture.
- Keys other than own are ignored in DEBOUNCE, HOLD and RELEASE.
  - A key still held when the FSM returns to IDLE is captured anew and can produce another event.
- Latency: a raw press to key_valid = 2 (synchroniser) + 1 (IDLE capture) + DEB_CYCLES cycles.
- key_valid is never high on two consecutive cycles.
- stop_level = 1 while own = 11 and the state is HOLD; otherwise 0.
- Counter width: cnt never exceeds DEB_CYCLES-1, so it never wraps.
- Simultaneous presses of keys 3 and 7 in the same cycle: key 3 is owned and reported; key 7 is reported only if it is still held after key 3 is released.
- Reset asserted mid-operation: no key_valid is produced; the FSM returns to IDLE immediately.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - HOLD also runs a 16-bit repeat counter, rpt.
  - While keys_s[own] stays 1, key_valid re-pulses with the same key_code every REPEAT_CYCLES cycles after the initial event.
  - rpt clears on entry to HOLD and on each repeat pulse.
  - Repeat applies to digit keys only; START and STOP never repeat.
- Undefined:
  - No rpt logic is present.
  - Exactly one event per press.

Decomposition:
- Shared package keypad_pkg:
  - State enum: IDLE, DEBOUNCE, HOLD, RELEASE.
  - Key-code constants: KEY_START = 4'd10, KEY_STOP = 4'd11.
  - N_KEYS default.
- One natural sub-module: key_sync, the parameterised N-bit two-flop synchroniser.

Test Plan:
- Basic press, DEB_CYCLES=4: keys_raw[5] high for 20 cycles, then low -> exactly one key_valid pulse, 7 cycles after the rise; key_code=5; busy falls after the release debounce.
- Bounce rejection: keys_raw[2] toggles high for 2 cycles, low for 1, repeated 5 times -> no key_valid; FSM returns to IDLE.
- Priority: keys_raw[3] and keys_raw[7] rise in the same cycle; key 3 released at cycle 30, key 7 held -> first event code 3; second event code 7 after key 3's release debounce plus the RELEASE cycle.
- Release glitch in HOLD: key 9 held; one-cycle low pulse mid-hold -> no second event; busy stays high.
- Reset mid-DEBOUNCE: reset pulse 2 cycles after the FSM enters DEBOUNCE -> outputs 0; no event; FSM restarts from IDLE when reset deasserts.
- KEY_REPEAT_EN, REPEAT_CYCLES=10: digit 4 held for 50 cycles -> initial event plus repeats every 10 cycles, all code 4; START held for 50 cycles -> single event only.
